// File: rtl/cmlink_cap_pkg.sv
// Shared definitions for the CameraLink frame-capture sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmlink_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int SOF_BIT       = 0;

endpackage

// File: rtl/cmlink_line_len_check.sv
// Per-line beat counter; flags lines that end early or run past line_pixels.
// Latency: error flag registers one cycle after the offending beat.
// Backpressure: none; observes accepted beats only, never stalls the stream.
module cmlink_line_len_check #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 clr,
  input  logic                 beat,
  input  logic                 sof,
  input  logic                 last,
  input  logic [CNT_WIDTH-1:0] line_pixels,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] pos;

  // Position of the current beat within its line; SOF always begins a new line.
  always_comb begin
    pos = (sof ? '0 : cnt_q) + ONE;
  end

  // Count beats per line and raise the sticky error on a short or long line.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else if (beat) begin
      if (last) begin
        cnt_q <= '0;
        if (pos != line_pixels) err <= 1'b1;
      end else begin
        cnt_q <= pos;
        if (pos == line_pixels) err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cameralink_capture_ctrl.sv
// Frame-aligned capture gate between the CameraLink receiver and DMA; counts lines/frames.
// Latency: zero-cycle combinational datapath; status registers update one cycle after a beat.
// Backpressure: downstream tready passes through while capturing; otherwise beats are dropped with tready=1.
// Optional: define CMLINK_CAP_LINE_CHECK_EN to add the per-line length check and err_line_len.
module cameralink_capture_ctrl
  import cmlink_cap_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_USER_WIDTH = 1,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         ctrl_start,
  input  logic                         ctrl_stop,
  input  logic                         cfg_continuous,
  input  logic [CNT_WIDTH-1:0]         cfg_frame_count,
  input  logic [CNT_WIDTH-1:0]         cfg_frame_lines,
  input  logic [CNT_WIDTH-1:0]         cfg_line_pixels,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0]   s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0]   m_axis_tuser,
  output logic [1:0]                   status_state,
  output logic [CNT_WIDTH-1:0]         status_frames,
  output logic [CNT_WIDTH-1:0]         status_lines,
`ifdef CMLINK_CAP_LINE_CHECK_EN
  output logic                         err_line_len,
`endif
  output logic                         err_short_frame
);

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  cap_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d, lines_q, lines_d;
  logic                 err_short_q, err_short_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 mid_line_q, mid_line_d;
  logic                 sh_cont_q;
  logic [CNT_WIDTH-1:0] sh_fcnt_q, sh_flines_q;

  logic                 sof, pass, acc, arm_go;
  logic                 start_frame, short_frame, line_end, frame_done, last_frame;
  logic [CNT_WIDTH-1:0] lines_inc, frames_inc;

  // Pass mux: forward while capturing or on the SOF beat that starts a capture; else drop.
  always_comb begin
    sof           = s_axis_tuser[SOF_BIT];
    pass          = (state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && sof);
    m_axis_tvalid = aresetn && pass && s_axis_tvalid;
    s_axis_tready = aresetn && (pass ? m_axis_tready : 1'b1);
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tlast  = s_axis_tlast;
    m_axis_tuser  = s_axis_tuser;
    acc           = s_axis_tvalid && s_axis_tready;
  end

  // Next-state and counter logic; a frame only ends on the configured line count.
  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    lines_d     = lines_q;
    err_short_d = err_short_q;
    stop_pend_d = stop_pend_q;
    mid_line_d  = mid_line_q;

    arm_go      = (state_q == ST_IDLE) && ctrl_start && !ctrl_stop &&
                  (cfg_frame_lines != '0) && (cfg_continuous || (cfg_frame_count != '0));
    start_frame = acc && sof && (state_q != ST_IDLE);
    short_frame = start_frame && (state_q == ST_CAPTURE) && ((lines_q != '0) || mid_line_q);
    lines_inc   = (start_frame ? '0 : lines_q) + ONE;
    line_end    = acc && pass && s_axis_tlast;
    frame_done  = line_end && (lines_inc == sh_flines_q);
    frames_inc  = frames_q + ONE;
    last_frame  = !sh_cont_q && (frames_inc == sh_fcnt_q);

    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (arm_go) begin
          state_d     = ST_ARMED;
          frames_d    = '0;
          lines_d     = '0;
          err_short_d = 1'b0;
          mid_line_d  = 1'b0;
        end
      end
      default: begin
        if ((state_q == ST_ARMED) && ctrl_stop) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
          mid_line_d  = 1'b0;
        end else begin
          if (ctrl_stop)   stop_pend_d = 1'b1;
          if (short_frame) err_short_d = 1'b1;
          if (start_frame) begin
            state_d = ST_CAPTURE;
            lines_d = '0;
          end
          if (acc && pass) mid_line_d = !s_axis_tlast;
          if (line_end)    lines_d = lines_inc;
          if (frame_done) begin
            frames_d   = frames_inc;
            lines_d    = '0;
            mid_line_d = 1'b0;
            if (stop_pend_q || ctrl_stop || last_frame) begin
              state_d     = ST_IDLE;
              stop_pend_d = 1'b0;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      frames_q    <= '0;
      lines_q     <= '0;
      err_short_q <= 1'b0;
      stop_pend_q <= 1'b0;
      mid_line_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frames_q    <= frames_d;
      lines_q     <= lines_d;
      err_short_q <= err_short_d;
      stop_pend_q <= stop_pend_d;
      mid_line_q  <= mid_line_d;
    end
  end

  // Shadow copy of the configuration, frozen for the whole capture.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sh_cont_q   <= 1'b0;
      sh_fcnt_q   <= '0;
      sh_flines_q <= '0;
    end else if (arm_go) begin
      sh_cont_q   <= cfg_continuous;
      sh_fcnt_q   <= cfg_frame_count;
      sh_flines_q <= cfg_frame_lines;
    end
  end

  assign status_state    = state_q;
  assign status_frames   = frames_q;
  assign status_lines    = lines_q;
  assign err_short_frame = err_short_q;

`ifdef CMLINK_CAP_LINE_CHECK_EN
  logic [CNT_WIDTH-1:0] sh_lpix_q;

  // Shadow line length, latched with the rest of the configuration.
  always_ff @(posedge aclk) begin
    if (!aresetn)    sh_lpix_q <= '0;
    else if (arm_go) sh_lpix_q <= cfg_line_pixels;
  end

  cmlink_line_len_check #(.CNT_WIDTH(CNT_WIDTH)) u_line_len_check (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .clr         (arm_go),
    .beat        (acc && pass),
    .sof         (start_frame),
    .last        (s_axis_tlast),
    .line_pixels (sh_lpix_q),
    .err         (err_line_len)
  );
`else
  logic unused_line_pixels;
  assign unused_line_pixels = ^cfg_line_pixels;
`endif

endmodule

// File: tb/tb_cameralink_capture_ctrl.sv
// Directed bench for cameralink_capture_ctrl with a beat scoreboard.
// Latency: checks combinational pass-through and registered status.
// Backpressure: exercises random downstream tready during an N-frame capture.
module tb_cameralink_capture_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        ctrl_start, ctrl_stop, cfg_continuous;
  logic [15:0] cfg_frame_count, cfg_frame_lines, cfg_line_pixels;
  logic [31:0] s_axis_tdata, m_axis_tdata;
  logic [3:0]  s_axis_tkeep, m_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [0:0]  s_axis_tuser, m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]  status_state;
  logic [15:0] status_frames, status_lines;
  logic        err_short_frame;
`ifdef CMLINK_CAP_LINE_CHECK_EN
  logic        err_line_len;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [37:0] sbq[$];
  logic [31:0] seq = 32'h1000;
  bit          rdy_rand = 1'b0;

  always #5 aclk = ~aclk;

  cameralink_capture_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .cfg_continuous(cfg_continuous), .cfg_frame_count(cfg_frame_count),
    .cfg_frame_lines(cfg_frame_lines), .cfg_line_pixels(cfg_line_pixels),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .status_state(status_state), .status_frames(status_frames), .status_lines(status_lines),
`ifdef CMLINK_CAP_LINE_CHECK_EN
    .err_line_len(err_line_len),
`endif
    .err_short_frame(err_short_frame)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    logic [37:0] exp;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      exp = sbq.pop_front();
      chk("sb_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, exp);
    end
  endtask

  // Present one beat (called at a negedge) and hold it until the DUT accepts it.
  task automatic send_beat(input logic last, input logic user, input logic [3:0] keep, input bit fwd);
    bit done = 1'b0;
    int n = 0;
    s_axis_tdata  = seq;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    if (fwd) sbq.push_back({seq, keep, last, user});
    seq = seq + 32'd1;
    while (!done && n < 100) begin
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!fwd) begin
        chk("discard_rdy", s_axis_tready, 64'd1);
        chk("discard_vld", m_axis_tvalid, 64'd0);
      end
      if (m_axis_tvalid && m_axis_tready) observe();
      done = s_axis_tready;
      @(negedge aclk);
      ctrl_start = 1'b0;
      ctrl_stop  = 1'b0;
      n++;
    end
    if (!done) chk("beat_timeout", 64'd0, 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_lines(input int nlines, input int npix, input bit sof, input bit fwd, input int stop_at);
    int b = 0;
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < npix; p++) begin
        if (b == stop_at) ctrl_stop = 1'b1;
        send_beat(p == npix - 1, sof && l == 0 && p == 0, (p == npix - 1) ? 4'h3 : 4'hF, fwd);
        b++;
      end
    end
  endtask

  task automatic pulse(input logic start, input logic stop);
    ctrl_start = start;
    ctrl_stop  = stop;
    @(negedge aclk);
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
  endtask

  task automatic cfg(input logic cont, input logic [15:0] fcnt, input logic [15:0] flines);
    cfg_continuous  = cont;
    cfg_frame_count = fcnt;
    cfg_frame_lines = flines;
  endtask

  initial begin
    aresetn = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0;
    cfg(1'b0, 16'd0, 16'd0);
    cfg_line_pixels = 16'd0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b1; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_s_tready", s_axis_tready, 64'd0);
    chk("rst_m_tvalid", m_axis_tvalid, 64'd0);
    aresetn = 1'b1; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    @(negedge aclk);
    chk("rst_state", status_state, 64'd0);
    chk("rst_frames", status_frames, 64'd0);
    chk("rst_lines", status_lines, 64'd0);
    chk("rst_err", err_short_frame, 64'd0);
    chk("idle_s_tready", s_axis_tready, 64'd1);

    // Single shot: start mid-frame, remainder dropped, next whole frame forwarded.
    cfg(1'b0, 16'd1, 16'd4);
    send_lines(4, 3, 1'b1, 1'b0, -1);
    send_lines(2, 3, 1'b1, 1'b0, -1);
    pulse(1'b1, 1'b0);
    chk("t1_armed", status_state, 64'd1);
    send_lines(2, 3, 1'b0, 1'b0, -1);
    send_lines(4, 3, 1'b1, 1'b1, -1);
    chk("t1_state", status_state, 64'd0);
    chk("t1_frames", status_frames, 64'd1);
    chk("t1_lines", status_lines, 64'd0);
    send_lines(4, 3, 1'b1, 1'b0, -1);
    chk("t1_sb_empty", sbq.size(), 64'd0);

    // N-frame capture under random downstream backpressure.
    cfg(1'b0, 16'd3, 16'd2);
    pulse(1'b1, 1'b0);
    rdy_rand = 1'b1;
    for (int f = 0; f < 3; f++) send_lines(2, 2, 1'b1, 1'b1, -1);
    rdy_rand = 1'b0;
    chk("t2_frames", status_frames, 64'd3);
    chk("t2_state", status_state, 64'd0);
    send_lines(2, 2, 1'b1, 1'b0, -1);
    chk("t2_sb_empty", sbq.size(), 64'd0);

    // Continuous; stop during line 1 of frame 5 lets frame 5 finish.
    cfg(1'b1, 16'd0, 16'd4);
    pulse(1'b1, 1'b0);
    for (int f = 0; f < 4; f++) send_lines(4, 2, 1'b1, 1'b1, -1);
    chk("t3_frames4", status_frames, 64'd4);
    chk("t3_armed", status_state, 64'd1);
    send_lines(4, 2, 1'b1, 1'b1, 1);
    chk("t3_state", status_state, 64'd0);
    chk("t3_frames", status_frames, 64'd5);
    send_lines(4, 2, 1'b1, 1'b0, -1);
    chk("t3_sb_empty", sbq.size(), 64'd0);

    // Short frame: SOF after two lines.
    cfg(1'b1, 16'd0, 16'd4);
    pulse(1'b1, 1'b0);
    send_lines(2, 2, 1'b1, 1'b1, -1);
    chk("t4_lines2", status_lines, 64'd2);
    chk("t4_err0", err_short_frame, 64'd0);
    send_beat(1'b0, 1'b1, 4'hF, 1'b1);
    chk("t4_err1", err_short_frame, 64'd1);
    chk("t4_lines_restart", status_lines, 64'd0);
    chk("t4_not_counted", status_frames, 64'd0);
    chk("t4_capture", status_state, 64'd2);
    send_beat(1'b1, 1'b0, 4'h3, 1'b1);
    send_lines(3, 2, 1'b0, 1'b1, -1);
    chk("t4_frames", status_frames, 64'd1);
    chk("t4_armed", status_state, 64'd1);
    pulse(1'b0, 1'b1);
    chk("t4_stop_armed", status_state, 64'd0);
    chk("t4_sb_empty", sbq.size(), 64'd0);

    // Start+stop together, and starts with illegal configuration, are ignored.
    pulse(1'b1, 1'b1);
    chk("t5_start_stop", status_state, 64'd0);
    chk("t5_err_kept", err_short_frame, 64'd1);
    cfg(1'b0, 16'd1, 16'd0);
    pulse(1'b1, 1'b0);
    chk("t5_zero_lines", status_state, 64'd0);
    cfg(1'b0, 16'd0, 16'd4);
    pulse(1'b1, 1'b0);
    chk("t5_zero_frames", status_state, 64'd0);

    // One-line, one-beat frames: SOF and tlast on the same beat.
    cfg(1'b0, 16'd2, 16'd1);
    pulse(1'b1, 1'b0);
    chk("t6_armed", status_state, 64'd1);
    chk("t6_err_clr", err_short_frame, 64'd0);
    send_lines(1, 1, 1'b1, 1'b1, -1);
    chk("t6_frames1", status_frames, 64'd1);
    send_lines(1, 1, 1'b1, 1'b1, -1);
    chk("t6_frames2", status_frames, 64'd2);
    chk("t6_state", status_state, 64'd0);
    chk("t6_sb_empty", sbq.size(), 64'd0);

`ifdef CMLINK_CAP_LINE_CHECK_EN
    // Line of 19 beats against a 20-beat configuration.
    cfg_line_pixels = 16'd20;
    cfg(1'b0, 16'd1, 16'd1);
    pulse(1'b1, 1'b0);
    chk("t7_len_err0", err_line_len, 64'd0);
    send_lines(1, 19, 1'b1, 1'b1, -1);
    chk("t7_len_err1", err_line_len, 64'd1);
    chk("t7_sb_empty", sbq.size(), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
